// File: rtl/router_port_rx.sv
// rtl/router_port_rx.sv - serial-to-byte receiver for one router input port
//
// Decodes frame_n/valid_n/din packets (serial address, pad cycles, LSB-first
// payload) into bytes tagged with address and end-of-packet, buffered in a FIFO.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   frame_n         active-low packet frame
//   valid_n         active-low data-bit qualifier (DATA phase only)
//   din             serial data
//   busy_n          registered active-low backpressure to the sender
//   m_valid/m_ready byte stream handshake toward the fabric
//   m_data/m_addr   payload byte and its destination address
//   m_last          last byte of the packet
//   err_pulse       one-cycle protocol or overflow error
//   pkt_count       packets completed without protocol error (wraps)
module router_port_rx #(
  parameter int ADDR_W      = 4,
  parameter int PAD_CYCLES  = 5,
  parameter int FIFO_DEPTH  = 16,
  parameter int BUSY_THRESH = FIFO_DEPTH - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              din,
  output logic              busy_n,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              err_pulse,
  output logic [15:0]       pkt_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AI_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int E_W   = ADDR_W + 9;

  localparam logic [2:0] S_ARMED = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_PAD   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_sr;
  logic [AI_W-1:0]   addr_cnt;
  logic [3:0]        pad_cnt;
  logic [7:0]        shift_r;
  logic [2:0]        bit_cnt;
  logic [7:0]        stg_data;
  logic              stg_full;

  logic [E_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              bit_take, byte_done, eof;
  logic [7:0]        shift_nxt;
  logic              push_a, push_b, fsm_err, pkt_ok;
  logic [E_W-1:0]    ent_a, ent_b;
  logic              pop, acc_a, acc_b, drop;
  logic [CNT_W-1:0]  space, count_nxt;
  logic [E_W-1:0]    head;

  assign bit_take  = (state == S_DATA) && !valid_n;
  assign shift_nxt = {din, shift_r[7:1]};
  assign byte_done = bit_take && (bit_cnt == 3'd7);
  assign eof       = (state == S_DATA) && frame_n;

  // Push selection. A byte completing on the end-of-frame cycle while the
  // staging slot is occupied needs two pushes in the same cycle.
  always_comb begin
    push_a  = 1'b0;
    push_b  = 1'b0;
    ent_a   = '0;
    ent_b   = '0;
    fsm_err = 1'b0;
    pkt_ok  = 1'b0;
    if (state == S_DATA) begin
      if (byte_done) begin
        if (stg_full) begin
          push_a = 1'b1;
          ent_a  = {addr_sr, 1'b0, stg_data};
          push_b = eof;
          ent_b  = {addr_sr, 1'b1, shift_nxt};
        end else if (eof) begin
          push_a = 1'b1;
          ent_a  = {addr_sr, 1'b1, shift_nxt};
        end
        pkt_ok = eof;
      end else if (eof) begin
        push_a = stg_full;
        ent_a  = {addr_sr, 1'b1, stg_data};
        // bit_take without byte_done leaves partial bits behind
        if (stg_full && (bit_cnt == 3'd0) && !bit_take) pkt_ok = 1'b1;
        else                                              fsm_err = 1'b1;
      end
    end else if ((state == S_ADDR || state == S_PAD) && frame_n) begin
      fsm_err = 1'b1;
    end
  end

  assign m_valid   = (count != '0);
  assign pop       = m_valid && m_ready;
  // A same-cycle pop frees a slot for this cycle's push.
  assign space     = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
  assign acc_a     = push_a && (space >= CNT_W'(1));
  assign acc_b     = push_b && (space >= CNT_W'(2));
  assign drop      = (push_a && !acc_a) || (push_b && !acc_b);
  assign count_nxt = count + CNT_W'(acc_a) + CNT_W'(acc_b) - CNT_W'(pop);

  assign head   = mem[rd_ptr];
  assign m_data = m_valid ? head[7:0] : 8'd0;
  assign m_last = m_valid && head[8];
  assign m_addr = m_valid ? head[E_W-1:9] : '0;

  always_ff @(posedge clk) begin
    if (acc_a) mem[wr_ptr] <= ent_a;
    if (acc_b) mem[wr_ptr + PTR_W'(1)] <= ent_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy_n    <= 1'b1;
      err_pulse <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(acc_a) + PTR_W'(acc_b);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      count     <= count_nxt;
      busy_n    <= !(count_nxt >= CNT_W'(BUSY_THRESH));
      err_pulse <= fsm_err || drop;
      pkt_count <= pkt_count + 16'(pkt_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_ARMED;
      addr_sr  <= '0;
      addr_cnt <= '0;
      pad_cnt  <= 4'd0;
      shift_r  <= 8'd0;
      bit_cnt  <= 3'd0;
      stg_data <= 8'd0;
      stg_full <= 1'b0;
    end else begin
      case (state)
        // Wait for frame_n high so a frame already in flight is ignored.
        S_ARMED: if (frame_n) state <= S_IDLE;
        S_IDLE: begin
          stg_full <= 1'b0;
          bit_cnt  <= 3'd0;
          if (!frame_n) begin
            addr_sr  <= ADDR_W'(din);
            addr_cnt <= AI_W'(1);
            pad_cnt  <= 4'd0;
            state    <= (ADDR_W == 1) ? S_PAD : S_ADDR;
          end
        end
        S_ADDR: begin
          if (frame_n) begin
            state <= S_IDLE;
          end else begin
            addr_sr[addr_cnt] <= din;
            addr_cnt          <= addr_cnt + AI_W'(1);
            if (addr_cnt == AI_W'(ADDR_W - 1)) state <= S_PAD;
          end
        end
        S_PAD: begin
          if (frame_n) begin
            state <= S_IDLE;
          end else begin
            pad_cnt <= pad_cnt + 4'd1;
            if (pad_cnt == 4'(PAD_CYCLES - 1)) state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_take) begin
            shift_r <= shift_nxt;
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (byte_done) begin
            stg_data <= shift_nxt;
            stg_full <= 1'b1;
          end
          if (frame_n) state <= S_IDLE;
        end
        default: state <= S_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_router_port_rx.sv
// tb/tb_router_port_rx.sv - directed scoreboard bench for router_port_rx
module tb_router_port_rx;

  logic        clk = 1'b0;
  logic        reset, frame_n, valid_n, din, m_ready;
  logic        busy_n, m_valid, m_last, err_pulse;
  logic [7:0]  m_data;
  logic [3:0]  m_addr;
  logic [15:0] pkt_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          err_seen = 0;
  int          e0;
  logic [12:0] exp_q [$];
  logic [12:0] exp_e;

  router_port_rx #(.ADDR_W(4), .PAD_CYCLES(5), .FIFO_DEPTH(16), .BUSY_THRESH(14)) dut (
    .clk(clk), .reset(reset), .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .busy_n(busy_n), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_addr(m_addr), .m_last(m_last), .err_pulse(err_pulse), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are stable between negedge and the next posedge, so a handshake
  // seen here completes at that posedge.
  always @(negedge clk) begin
    if (err_pulse === 1'b1) err_seen++;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_with_empty_model", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_e = exp_q.pop_front();
        chk("entry", 32'({m_addr, m_last, m_data}), 32'(exp_e));
      end
    end
  end

  task automatic drive(input logic f, input logic v, input logic d);
    @(posedge clk);
    #2;
    frame_n = f;
    valid_n = v;
    din     = d;
  endtask

  task automatic send(input logic [3:0] a, input logic [31:0] bits, input int nbits,
                      input int gap, input bit sep_end, input int abort_pad, input bit ready_end);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, a[i]);
    for (int p = 0; p < 5; p++) begin
      if (p == abort_pad) begin
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        return;
      end
      drive(1'b0, 1'b1, 1'b0);
    end
    for (int b = 0; b < nbits; b++) begin
      if (b > 0) repeat (gap) drive(1'b0, 1'b1, 1'b0);
      drive((b == nbits - 1) && !sep_end, 1'b0, bits[b]);
      if (b == nbits - 1 && ready_end) m_ready = 1'b1;
    end
    if (sep_end) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    if (ready_end) m_ready = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && m_valid === 1'b0) break;
    end
    @(negedge clk);
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_m_valid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy_n", 32'(busy_n), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);

    // two-byte packet, last bit carried on the frame_n rising cycle
    e0 = err_seen;
    exp_q.push_back({4'hA, 1'b0, 8'h3C});
    exp_q.push_back({4'hA, 1'b1, 8'hF0});
    send(4'hA, 32'h0000F03C, 16, 0, 1'b0, 9, 1'b0);
    drain();
    chk("t1_pkt_count", 32'(pkt_count), 32'd1);
    chk("t1_err", 32'(err_seen - e0), 32'd0);

    // same packet with 3-cycle valid_n gaps and a separate end-of-frame cycle
    e0 = err_seen;
    exp_q.push_back({4'hA, 1'b0, 8'h3C});
    exp_q.push_back({4'hA, 1'b1, 8'hF0});
    send(4'hA, 32'h0000F03C, 16, 3, 1'b1, 9, 1'b0);
    @(negedge clk);
    chk("t2_last_valid", 32'(m_valid), 32'd1);
    chk("t2_last_flag", 32'(m_last), 32'd1);
    chk("t2_last_data", 32'(m_data), 32'hF0);
    drain();
    chk("t2_pkt_count", 32'(pkt_count), 32'd2);
    chk("t2_err", 32'(err_seen - e0), 32'd0);

    // 11-bit payload: one byte delivered as last, error, count unchanged
    e0 = err_seen;
    exp_q.push_back({4'hA, 1'b1, 8'h5A});
    send(4'hA, 32'h0000055A, 11, 0, 1'b0, 9, 1'b0);
    drain();
    chk("t3_err", 32'(err_seen - e0), 32'd1);
    chk("t3_pkt_count", 32'(pkt_count), 32'd2);

    // abort during PAD, then a good packet
    e0 = err_seen;
    send(4'hA, 32'd0, 0, 0, 1'b0, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("t4_no_entry", 32'(m_valid), 32'd0);
    chk("t4_err", 32'(err_seen - e0), 32'd1);
    exp_q.push_back({4'h3, 1'b1, 8'h81});
    send(4'h3, 32'h00000081, 8, 0, 1'b0, 9, 1'b0);
    drain();
    chk("t4_pkt_count", 32'(pkt_count), 32'd3);

    // fill with m_ready low: busy at 14, drop on the 17th push
    m_ready = 1'b0;
    e0 = err_seen;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) exp_q.push_back({4'(k), 1'b1, 8'(16 + k)});
      send(4'(k), 32'(16 + k), 8, 0, 1'b0, 9, 1'b0);
      @(negedge clk);
      if (k == 13) chk("t5_busy_at_13", 32'(busy_n), 32'd1);
      if (k == 14) chk("t5_busy_at_14", 32'(busy_n), 32'd0);
    end
    @(negedge clk);
    chk("t5_overflow_err", 32'(err_seen - e0), 32'd1);
    chk("t5_full_busy", 32'(busy_n), 32'd0);
    // push into a full FIFO while popping in the same cycle
    e0 = err_seen;
    exp_q.push_back({4'h2, 1'b1, 8'h99});
    send(4'h2, 32'h00000099, 8, 0, 1'b0, 9, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_pop_push_no_err", 32'(err_seen - e0), 32'd0);
    chk("t5_still_busy", 32'(busy_n), 32'd0);
    drain();

    // reset mid-DATA with frame_n held low across release
    m_ready = 1'b0;
    send(4'h5, 32'h00000042, 8, 0, 1'b0, 9, 1'b0);
    @(negedge clk);
    chk("t6_entry_before_rst", 32'(m_valid), 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1);
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_busy_n", 32'(busy_n), 32'd1);
    chk("t6_rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("t6_rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    e0 = err_seen;
    repeat (20) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_held_frame_ignored", 32'(m_valid), 32'd0);
    chk("t6_held_frame_no_err", 32'(err_seen - e0), 32'd0);
    m_ready = 1'b1;
    exp_q.push_back({4'h5, 1'b1, 8'h77});
    send(4'h5, 32'h00000077, 8, 0, 1'b0, 9, 1'b0);
    drain();
    chk("t6_pkt_count", 32'(pkt_count), 32'd1);
    chk("t6_err", 32'(err_seen - e0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
